// File: rtl/isa_io_trap_if.sv
`default_nettype none
// ============================================================
// Interface : isa_io_trap_if
// Purpose   : Pi-side valid/ready stream of {addr[9:0], data[7:0]} entries
// Revision  : 1.0 - initial release
// ============================================================
interface isa_io_trap_if;
   logic [17:0] m_data;
   logic        m_valid;
   logic        m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface
`default_nettype wire

// File: rtl/isa_io_trap.sv
`default_nettype none
// ============================================================
// Module   : isa_io_trap
// Purpose  : traps ISA I/O writes hitting NUM_WIN windows into a FWFT FIFO,
//            stretches cycles with CHRDY when full, counts drops.
//            Define ISA_IO_TRAP_SHADOW_EN to answer reads from a shadow RAM.
// Revision : 1.0 - initial release
// ============================================================
module isa_io_trap #(
   parameter int                    NUM_WIN         = 2,
   parameter logic [NUM_WIN*10-1:0] WIN_BASE        = {10'h388, 10'h340},
   parameter logic [NUM_WIN*4-1:0]  WIN_SPAN_LOG2   = {4'd1, 4'd3},
   parameter int                    FIFO_DEPTH_LOG2 = 4,
   parameter int                    WAIT_MAX        = 511
) (
   input  wire                        clk,
   input  wire                        rst,
   input  wire  [9:0]                 isa_addr,
   input  wire                        isa_aen,
   input  wire                        isa_iow_n,
   input  wire                        isa_ior_n,
   input  wire  [7:0]                 isa_d_in,
   output logic [7:0]                 isa_d_out,
   output logic                       isa_d_oe,
   output logic                       isa_chrdy_low,
   isa_io_trap_if.master              m,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
   output logic [15:0]                overflow_cnt
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CW    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
   localparam logic [FIFO_DEPTH_LOG2:0]   FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [FIFO_DEPTH_LOG2:0]   LVL_ONE    = (FIFO_DEPTH_LOG2 + 1)'(1);
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);
   localparam logic [CW-1:0]              CNT_ONE    = CW'(1);

   function automatic logic win_hit(input logic [9:0] a, input int i);
      logic [3:0] s;
      s = WIN_SPAN_LOG2[4*i +: 4];
      return (a >> s) == (WIN_BASE[10*i +: 10] >> s);
   endfunction

   // [0],[1] synchroniser flops, [2] edge register
   logic [2:0] iow_sync, ior_sync;
   logic       iow_fall, iow_rise, ior_fall, ior_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iow_sync <= 3'b111;
         ior_sync <= 3'b111;
      end else begin
         iow_sync <= {iow_sync[1:0], isa_iow_n};
         ior_sync <= {ior_sync[1:0], isa_ior_n};
      end
   end

   assign iow_fall = iow_sync[2] & ~iow_sync[1];
   assign iow_rise = ~iow_sync[2] & iow_sync[1];
   assign ior_fall = ior_sync[2] & ~ior_sync[1];
   assign ior_rise = ~ior_sync[2] & ior_sync[1];

   logic hit, qual;
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NUM_WIN; i++)
         if (win_hit(isa_addr, i)) hit = 1'b1;
   end
   assign qual = hit & ~isa_aen;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_ACT = 2'd1,
      RD_ACT = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   wait_cnt;
   logic [9:0]      lat_addr;
   logic            valid_r, full, pop, push, drop, accept;
   logic            enter_wr, enter_rd, wr_done, rd_done;

   assign full     = (fifo_level == FULL_LEVEL);
   assign pop      = valid_r & m.m_ready;
   // write wins when both strobes fall in the same clk
   assign enter_wr = (state == IDLE) && iow_fall && qual;
   assign enter_rd = (state == IDLE) && ior_fall && !iow_fall && qual;
   assign wr_done  = (state == WR_ACT) && iow_rise;
   assign rd_done  = (state == RD_ACT) && ior_rise;
   assign accept   = !full || pop;
   assign push     = wr_done && accept;
   assign drop     = wr_done && !accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         isa_chrdy_low <= 1'b0;
         wait_cnt      <= '0;
         lat_addr      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enter_wr) begin
                  state         <= WR_ACT;
                  lat_addr      <= isa_addr;
                  isa_chrdy_low <= full && (WAIT_MAX > 0);
                  wait_cnt      <= CW'(WAIT_MAX);
               end else if (enter_rd) begin
                  state    <= RD_ACT;
                  lat_addr <= isa_addr;
               end
            end
            WR_ACT: begin
               if (wr_done) begin
                  state         <= IDLE;
                  isa_chrdy_low <= 1'b0;
               end else if (isa_chrdy_low) begin
                  // release on the clk the counter hits 0 so CHRDY is low WAIT_MAX clks
                  wait_cnt <= wait_cnt - CNT_ONE;
                  if (!full || wait_cnt <= CNT_ONE)
                     isa_chrdy_low <= 1'b0;
               end
            end
            RD_ACT: begin
               if (rd_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [17:0]                mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [FIFO_DEPTH_LOG2:0]   level_nxt;

   always_comb begin
      level_nxt = fifo_level;
      if (push && !pop)
         level_nxt = fifo_level + LVL_ONE;
      else if (pop && !push)
         level_nxt = fifo_level - LVL_ONE;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {lat_addr, isa_d_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         valid_r      <= 1'b0;
         overflow_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         fifo_level <= level_nxt;
         valid_r    <= (level_nxt != '0);
         if (drop && overflow_cnt != 16'hFFFF)
            overflow_cnt <= overflow_cnt + 16'd1;
      end
   end

   assign m.m_valid = valid_r;
   assign m.m_data  = mem[rd_ptr];

`ifdef ISA_IO_TRAP_SHADOW_EN
   function automatic int win_off(input int w);
      int s;
      s = 0;
      for (int i = 0; i < w; i++) s += 1 << WIN_SPAN_LOG2[4*i +: 4];
      return s;
   endfunction

   localparam int SH_SIZE = win_off(NUM_WIN);
   localparam int SW      = (SH_SIZE > 1) ? $clog2(SH_SIZE) : 1;

   logic [7:0]    shadow [SH_SIZE];
   logic [SW-1:0] sh_idx, sh_idx_lat;

   // descending scan so the lowest-index window wins on overlap
   always_comb begin
      sh_idx = '0;
      for (int i = NUM_WIN - 1; i >= 0; i--)
         if (win_hit(isa_addr, i))
            sh_idx = SW'(win_off(i) + int'(isa_addr &
                     ((10'd1 << WIN_SPAN_LOG2[4*i +: 4]) - 10'd1)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SH_SIZE; i++) shadow[i] <= 8'hFF;
         sh_idx_lat <= '0;
         isa_d_out  <= '0;
         isa_d_oe   <= 1'b0;
      end else begin
         if (enter_wr || enter_rd) sh_idx_lat <= sh_idx;
         if (wr_done) shadow[sh_idx_lat] <= isa_d_in;
         if (enter_rd) begin
            isa_d_out <= shadow[sh_idx];
            isa_d_oe  <= 1'b1;
         end else if (rd_done) begin
            isa_d_oe  <= 1'b0;
         end
      end
   end
`else
   assign isa_d_out = '0;
   assign isa_d_oe  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/isa_io_trap.md
Name: isa_io_trap

Overview:
- Parametrised ISA I/O-port trap for the ISA-to-Pi bridge.
- Captures ISA writes that hit any of NUM_WIN address windows and queues them as {address, data} entries in a FIFO.
- The Pi-side serializer drains the FIFO through a valid/ready stream.
- Stretches ISA cycles with CHRDY when the FIFO is full, counts dropped writes, and optionally answers reads from a shadow register file.

Parameters:
- NUM_WIN, 2, number of trapped address windows (1..8).
- WIN_BASE, {10'h388, 10'h340}, packed NUM_WIN*10 bits; base of window i at [10i+9:10i]; base is aligned to the window span.
- WIN_SPAN_LOG2, {4'd1, 4'd3}, packed NUM_WIN*4 bits; window i covers 2^span ports (span 0..6).
- FIFO_DEPTH_LOG2, 4, FIFO depth is 2^n entries (n 2..10).
- WAIT_MAX, 511, maximum clk cycles CHRDY is held low per ISA cycle.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- isa_addr  in  10  ISA SA[9:0]
- isa_aen  in  1  ISA AEN; 1 = DMA cycle, ignore the bus
- isa_iow_n  in  1  ISA IOW#, asynchronous
- isa_ior_n  in  1  ISA IOR#, asynchronous
- isa_d_in  in  8  ISA data bus input
- isa_d_out  out  8  ISA read data
- isa_d_oe  out  1  drive isa_d_out onto the bus
- isa_chrdy_low  out  1  1 = pull CHRDY low (open-drain at the pad)
- m_data  out  18  {isa_addr[9:0], data[7:0]} of the FIFO head
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer accepts the head entry
- fifo_level  out  FIFO_DEPTH_LOG2+1  current occupancy
- overflow_cnt  out  16  dropped writes, saturating

Behaviour:
- Reset (asynchronous, active-high) clears the following; a reset asserted mid-ISA-cycle releases CHRDY and the data bus immediately.
  - FIFO pointers and contents-valid
  - all outputs to 0: isa_d_oe, isa_chrdy_low, m_valid, fifo_level, overflow_cnt, isa_d_out
  - synchronisers to 1 (idle strobes)
  - state machine to IDLE
- Strobe conditioning:
  - IOW#/IOR# pass through 2-flop synchronisers plus an edge register.
  - Falling and rising edges are detected on the synchronised value, so edge latency is 3 clk.
- Address hit: window i is hit when (isa_addr >> span_i) == (base_i >> span_i). The lowest-index window wins if windows overlap. No hit, or isa_aen=1, is ignored entirely.
- Address/hit latching: at a qualifying strobe falling edge, isa_addr and the hit flag are latched and held for the whole cycle.
- Write FSM: IDLE -> WR_ACT -> IDLE.
  - IDLE: on a qualifying IOW# fall, go to WR_ACT.
  - WR_ACT entry: if the FIFO is full, set isa_chrdy_low=1 and load the wait counter with WAIT_MAX.
  - While in WR_ACT: release isa_chrdy_low when the FIFO becomes not-full or the counter reaches 0.
  - IOW# rise: sample isa_d_in, then do exactly one of the following and return to IDLE.
    - push {latched addr, data} if not full, or
    - increment overflow_cnt (saturates at 16'hFFFF) if full.
- Read FSM: IDLE -> RD_ACT -> IDLE.
  - On a qualifying IOR# fall, go to RD_ACT.
  - In RD_ACT, behaviour follows the optional feature below.
  - IOR# rise returns to IDLE with isa_d_oe=0 in the same cycle.
- IOW# and IOR# falling in the same clk: the write takes priority and the read is ignored.
- FIFO:
  - First-word-fall-through; m_data is valid whenever m_valid=1.
  - Pop when m_valid && m_ready.
  - Push and pop in the same clk are both performed, including when full (the pop frees the slot) and when empty (no bypass; the entry appears on the next clk).
  - fifo_level is updated registered, one clk after the push/pop.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2.
- Ordering: entries are delivered in ISA write order; no coalescing.

Optional Feature:
- Macro: ISA_IO_TRAP_SHADOW_EN.
- Defined:
  - Adds a shadow RAM with one byte per trapped port (sum of 2^span_i entries), reset to 8'hFF.
  - Every accepted or dropped write updates the shadow byte.
  - On RD_ACT entry, isa_d_out is loaded with the shadow byte of the latched address and isa_d_oe=1 on the next clk.
- Undefined:
  - No shadow RAM; isa_d_oe stays 0 permanently and reads are never driven.
  - isa_d_out is tied to 0.

Test Plan:
- Write 8'h5A to port 10'h342 (IOW# low 20 clk) -> one entry m_data=18'h342_5A appears; m_valid=1 by 3 clk after IOW# rise; fifo_level=1.
- Write to 10'h300, and write to 10'h388 with isa_aen=1 -> no push; fifo_level stays 0; chrdy never asserted.
- m_ready=0; 16 writes to 10'h389 (D=0..15), then a 17th with IOW# held 600 clk -> isa_chrdy_low=1 for exactly WAIT_MAX=511 clk then released; at IOW# rise overflow_cnt=1, fifo_level=16.
- FIFO full; write starts; m_ready pulsed 1 clk after 50 clk of wait -> isa_chrdy_low released within 1 clk of the pop; write accepted; overflow_cnt=0; FIFO order 0..15 then new entry.
- With ISA_IO_TRAP_SHADOW_EN: write 8'hC3 to 10'h345, then read 10'h345 -> isa_d_out=8'hC3, isa_d_oe=1 until IOR# rise; read of never-written 10'h346 -> 8'hFF. Without the macro -> isa_d_oe stays 0.
- Assert rst while isa_chrdy_low=1 with the FIFO holding 5 entries -> all outputs 0 asynchronously; m_valid=0; first post-reset write produces a single entry.
